// File: rtl/arbitro_bcd.sv
// Round-robin arbiter that time-shares one combinational binary->BCD converter
// between N_REQ requesters and returns registered decenas/unidades with the owner id.
module arbitro_bcd #(
    parameter int N_REQ     = 4,
    parameter int W         = 5,
    parameter int CONV_WAIT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*W-1:0]       bin_flat,
    output logic [N_REQ-1:0]         gnt,
    output logic [W-1:0]             conv_bin,
    input  logic [3:0]               conv_u,
    input  logic [3:0]               conv_d,
    output logic [3:0]               U,
    output logic [3:0]               D,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] id,
    output logic                     busy,
    output logic                     err
);

    // state | meaning
    // IDLE  | no conversion in flight; winner chosen from req
    // LOAD  | grant pulse; winner operand latched into conv_bin
    // WAIT  | converter settling; result captured when cnt reaches 0
    // DONE  | valid pulse; round-robin pointer advances past the owner

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state, nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] id_int;
    logic [IW-1:0] win;
    logic [IW:0]   idx;
    logic          found;
    logic [3:0]    cnt;

    // scan ptr, ptr+1, ... wrapping at N_REQ so non-power-of-two sizes never grant a ghost index
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(N_REQ))
                idx = idx - (IW+1)'(N_REQ);
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt   = state;
        gnt   = '0;
        valid = 1'b0;
        busy  = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (|req)
                    nxt = LOAD;
            end
            LOAD: begin
                gnt[id_int] = 1'b1;
                nxt         = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0)
                    nxt = DONE;
            end
            DONE: begin
                valid = 1'b1;
                nxt   = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            id_int   <= '0;
            conv_bin <= '0;
            cnt      <= 4'd0;
            U        <= 4'd0;
            D        <= 4'd0;
            id       <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req)
                        id_int <= win;
                end
                LOAD: begin
                    conv_bin <= bin_flat[id_int*W +: W];
                    cnt      <= 4'(CONV_WAIT - 1);
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        U  <= conv_u;
                        D  <= conv_d;
                        id <= id_int;
                        // out-of-range digits are still delivered; err just flags them
                        if (conv_u > 4'd9 || conv_d > 4'd3)
                            err <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (id == IW'(N_REQ - 1))
                        ptr <= '0;
                    else
                        ptr <= id + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_bcd.sv
// Directed bench for arbitro_bcd: shared converter modelled in the bench,
// outputs sampled on the falling edge, inputs driven on the falling edge.
module tb_arbitro_bcd;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [19:0] bin_flat;
    logic [3:0]  gnt;
    logic [4:0]  conv_bin;
    logic [3:0]  conv_u;
    logic [3:0]  conv_d;
    logic [3:0]  U;
    logic [3:0]  D;
    logic        valid;
    logic [1:0]  id;
    logic        busy;
    logic        err;
    logic        bad_u;

    int total = 0;
    int bad   = 0;

    arbitro_bcd #(.N_REQ(4), .W(5), .CONV_WAIT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .bin_flat (bin_flat),
        .gnt      (gnt),
        .conv_bin (conv_bin),
        .conv_u   (conv_u),
        .conv_d   (conv_d),
        .U        (U),
        .D        (D),
        .valid    (valid),
        .id       (id),
        .busy     (busy),
        .err      (err)
    );

    // reference binary->BCD converter, with a stuck-digit fault switch
    assign conv_d = 4'(conv_bin / 5'd10);
    assign conv_u = bad_u ? 4'd12 : 4'(conv_bin % 5'd10);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // starts at a falling edge in IDLE with req already driven; ends at the falling edge of the next IDLE
    task automatic do_conv(input string tag, input logic [3:0] eg, input logic [4:0] eb,
                           input logic [3:0] ed, input logic [3:0] eu, input logic [1:0] eid,
                           input bit drop);
        @(negedge clk);
        chk({tag, "_gnt"}, gnt, eg);
        chk({tag, "_busy"}, busy, 1'b1);
        @(negedge clk);
        chk({tag, "_bin"}, conv_bin, eb);
        chk({tag, "_gnt_off"}, gnt, 4'b0000);
        if (drop) req = 4'b0000;
        @(negedge clk);
        chk({tag, "_valid"}, valid, 1'b1);
        chk({tag, "_d"}, D, ed);
        chk({tag, "_u"}, U, eu);
        chk({tag, "_id"}, id, eid);
        @(negedge clk);
        chk({tag, "_valid_off"}, valid, 1'b0);
        chk({tag, "_hold_u"}, U, eu);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [4:0] bnd_v [8];
    logic [3:0] bnd_d [8];
    logic [3:0] bnd_u [8];

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        bin_flat = '0;
        bad_u    = 1'b0;
        bnd_v = '{5'd0, 5'd9, 5'd10, 5'd19, 5'd20, 5'd29, 5'd30, 5'd31};
        bnd_d = '{4'd0, 4'd0, 4'd1,  4'd1,  4'd2,  4'd2,  4'd3,  4'd3};
        bnd_u = '{4'd0, 4'd9, 4'd0,  4'd9,  4'd0,  4'd9,  4'd0,  4'd1};

        @(negedge clk);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_bin", conv_bin, 5'd0);
        chk("rst_ud", {D, U}, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_id", id, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // single requester
        bin_flat[4:0] = 5'd27;
        req = 4'b0001;
        do_conv("t1", 4'b0001, 5'd27, 4'd2, 4'd7, 2'd0, 1'b1);

        // all four held: strict rotation, back to 0 after 3
        do_reset();
        bin_flat = {5'd31, 5'd25, 5'd14, 5'd3};
        req = 4'b1111;
        do_conv("t2a", 4'b0001, 5'd3,  4'd0, 4'd3, 2'd0, 1'b0);
        do_conv("t2b", 4'b0010, 5'd14, 4'd1, 4'd4, 2'd1, 1'b0);
        do_conv("t2c", 4'b0100, 5'd25, 4'd2, 4'd5, 2'd2, 1'b0);
        do_conv("t2d", 4'b1000, 5'd31, 4'd3, 4'd1, 2'd3, 1'b0);
        do_conv("t2e", 4'b0001, 5'd3,  4'd0, 4'd3, 2'd0, 1'b1);

        // decade boundaries through requester 1
        for (int i = 0; i < 8; i++) begin
            bin_flat[9:5] = bnd_v[i];
            req = 4'b0010;
            do_conv($sformatf("t3_%0d", bnd_v[i]), 4'b0010, bnd_v[i], bnd_d[i], bnd_u[i], 2'd1, 1'b1);
        end

        // operand and req change after LOAD must not disturb the conversion
        bin_flat[14:10] = 5'd12;
        req = 4'b0100;
        @(negedge clk);
        chk("t4_gnt", gnt, 4'b0100);
        @(negedge clk);
        bin_flat[14:10] = 5'd30;
        req = 4'b0000;
        chk("t4_bin", conv_bin, 5'd12);
        @(negedge clk);
        chk("t4_valid", valid, 1'b1);
        chk("t4_du", {D, U}, {4'd1, 4'd2});
        chk("t4_id", id, 2'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_no_regrant", {valid, gnt}, 5'd0);
        end

        // reset in WAIT abandons the conversion and the rotation
        bin_flat[19:15] = 5'd17;
        req = 4'b1000;
        @(negedge clk);
        chk("t5_gnt", gnt, 4'b1000);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_ud", {D, U}, 8'h00);
        chk("t5_bin", conv_bin, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_valid", valid, 1'b0);
        end
        chk("t5_id", id, 2'd0);
        bin_flat[9:5] = 5'd21;
        req = 4'b1010;
        do_conv("t5_next", 4'b0010, 5'd21, 4'd2, 4'd1, 2'd1, 1'b1);

        // bad converter digit: captured, flagged, and err is sticky
        chk("t6_err_pre", err, 1'b0);
        bad_u = 1'b1;
        bin_flat[4:0] = 5'd5;
        req = 4'b0001;
        do_conv("t6_bad", 4'b0001, 5'd5, 4'd0, 4'd12, 2'd0, 1'b1);
        chk("t6_err_set", err, 1'b1);
        bad_u = 1'b0;
        bin_flat[4:0] = 5'd31;
        req = 4'b0001;
        do_conv("t6_good", 4'b0001, 5'd31, 4'd3, 4'd1, 2'd0, 1'b1);
        chk("t6_err_sticky", err, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_err_clr", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
